// File: rtl/core_dispatcher.sv
// core_dispatcher: hands output-row indices of a matrix-multiply job to a
// pool of processor cores. Idle cores are picked round-robin, busy cores are
// tracked through start/done handshakes, and the job ends once every row has
// been issued and every core has reported completion.
module core_dispatcher #(
   parameter int NUM_CORES = 4,
   parameter int ROW_W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ROW_W-1:0]           num_rows,
   input  logic [NUM_CORES-1:0]       core_done,
   output logic [NUM_CORES-1:0]       core_start,
   output logic [NUM_CORES*ROW_W-1:0] core_row,
   output logic                       busy,
   output logic                       all_done,
   output logic [ROW_W-1:0]           rows_issued
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DISPATCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [ROW_W-1:0]           total_q, total_d;
   logic [ROW_W-1:0]           next_row_q, next_row_d;
   logic [ROW_W-1:0]           rows_issued_q, rows_issued_d;
   logic [NUM_CORES-1:0]       core_busy_q, core_busy_d;
   logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic [NUM_CORES-1:0]       core_start_q, core_start_d;
   logic [NUM_CORES*ROW_W-1:0] core_row_q, core_row_d;
   logic                       busy_q, busy_d;
   logic                       all_done_q, all_done_d;

   logic                       issue_valid;
   logic [PTR_W-1:0]           issue_idx;
   logic [NUM_CORES-1:0]       issue_onehot;

   // Round-robin pick of the first idle core at or after rr_ptr, using only
   // the registered busy mask so a core finishing this cycle waits one cycle.
   always_comb begin
      int               cand;
      logic [PTR_W-1:0] cand_idx;
      // NOTE: every variable gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      cand         = 0;
      cand_idx     = '0;
      issue_valid  = 1'b0;
      issue_idx    = '0;
      issue_onehot = '0;
      if (state_q == S_DISPATCH) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            cand_idx = PTR_W'(cand);
            if (!issue_valid && !core_busy_q[cand_idx]) begin
               issue_valid            = 1'b1;
               issue_idx              = cand_idx;
               issue_onehot[cand_idx] = 1'b1;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples pre-edge values regardless of block evaluation order.
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (num_rows == '0) ? S_DONE : S_DISPATCH;
         end
         S_DISPATCH: begin
            // The issue that hands out the last row ends dispatching.
            if (issue_valid && (ROW_W'(next_row_q + 1'b1) == total_q)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if ((core_busy_q & ~core_done) == '0) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM-derived outputs, registered so they line up with the new state.
   always_comb begin
      busy_d     = (state_d != S_IDLE);
      all_done_d = (state_d == S_DONE);
   end

   // Job datapath: row counters, busy mask, round-robin pointer, core outputs.
   always_comb begin
      total_d       = total_q;
      next_row_d    = next_row_q;
      rows_issued_d = rows_issued_q;
      core_busy_d   = core_busy_q;
      rr_ptr_d      = rr_ptr_q;
      core_start_d  = '0;
      core_row_d    = core_row_q;
      if (state_q == S_IDLE) begin
         if (start) begin
            total_d       = num_rows;
            next_row_d    = '0;
            rows_issued_d = '0;
            core_busy_d   = '0;
            rr_ptr_d      = '0;
         end
      end else begin
         // Done on an idle core falls out of the mask naturally; an issued
         // core is always idle in the registered mask, so it never collides
         // with a done bit that is honoured.
         core_busy_d = (core_busy_q & ~core_done) | issue_onehot;
         if (issue_valid) begin
            core_start_d  = issue_onehot;
            next_row_d    = next_row_q + 1'b1;
            rows_issued_d = rows_issued_q + 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
               if (issue_onehot[i]) core_row_d[i*ROW_W +: ROW_W] = next_row_q;
            end
            if (int'(issue_idx) == NUM_CORES - 1) rr_ptr_d = '0;
            else                                  rr_ptr_d = issue_idx + PTR_W'(1);
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         total_q       <= '0;
         next_row_q    <= '0;
         rows_issued_q <= '0;
         core_busy_q   <= '0;
         rr_ptr_q      <= '0;
         core_start_q  <= '0;
         core_row_q    <= '0;
         busy_q        <= 1'b0;
         all_done_q    <= 1'b0;
      end else begin
         total_q       <= total_d;
         next_row_q    <= next_row_d;
         rows_issued_q <= rows_issued_d;
         core_busy_q   <= core_busy_d;
         rr_ptr_q      <= rr_ptr_d;
         core_start_q  <= core_start_d;
         core_row_q    <= core_row_d;
         busy_q        <= busy_d;
         all_done_q    <= all_done_d;
      end
   end

   assign core_start  = core_start_q;
   assign core_row    = core_row_q;
   assign busy        = busy_q;
   assign all_done    = all_done_q;
   assign rows_issued = rows_issued_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// tb_core_dispatcher: directed and randomized jobs for core_dispatcher,
// compared every cycle against a job-level reference model.
module tb_core_dispatcher;

   localparam int NC = 4;
   localparam int RW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [RW-1:0]     num_rows;
   logic [NC-1:0]     core_done;
   logic [NC-1:0]     core_start;
   logic [NC*RW-1:0]  core_row;
   logic              busy;
   logic              all_done;
   logic [RW-1:0]     rows_issued;

   core_dispatcher #(.NUM_CORES(NC), .ROW_W(RW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_rows    (num_rows),
      .core_done   (core_done),
      .core_start  (core_start),
      .core_row    (core_row),
      .busy        (busy),
      .all_done    (all_done),
      .rows_issued (rows_issued)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: job phase 0 idle, 1 handing out rows, 2 waiting for
   // the last cores, 3 completion cycle.
   int               m_phase;
   bit               m_busy [NC];
   int               m_age  [NC];
   int               m_ptr, m_next, m_total;
   logic [NC-1:0]    exp_start;
   logic [NC*RW-1:0] exp_row;
   logic             exp_busy, exp_done;
   logic [RW-1:0]    exp_issued;

   int obs_starts, obs_dones, obs_dups, n_seen;
   bit row_seen [2**RW];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_next = 0; m_total = 0;
      for (int i = 0; i < NC; i++) begin m_busy[i] = 0; m_age[i] = 0; end
      exp_start = '0; exp_row = '0; exp_busy = 0; exp_done = 0; exp_issued = '0;
   endtask

   // Advance the model by one clock edge using the inputs applied for it.
   task automatic model_step();
      int found;
      int c;
      bit any;
      if (rst) begin model_reset(); return; end
      exp_start = '0;
      found = -1;
      if (m_phase == 0) begin
         if (start) begin
            m_total = int'(num_rows); m_next = 0; m_ptr = 0;
            for (int i = 0; i < NC; i++) m_busy[i] = 0;
            m_phase = (num_rows == 0) ? 3 : 1;
         end
      end else begin
         if (m_phase == 1) begin
            for (int k = 0; k < NC; k++) begin
               c = (m_ptr + k) % NC;
               if (found < 0 && !m_busy[c]) found = c;
            end
         end
         for (int i = 0; i < NC; i++) begin
            if (core_done[i]) m_busy[i] = 0;
            if (m_busy[i]) m_age[i]++;
         end
         if (found >= 0) begin
            exp_start[found] = 1'b1;
            exp_row[found*RW +: RW] = RW'(m_next);
            m_busy[found] = 1; m_age[found] = 0;
            m_next++;
            m_ptr = (found + 1) % NC;
            if (m_next == m_total) m_phase = 2;
         end else if (m_phase == 2) begin
            any = 0;
            for (int i = 0; i < NC; i++) any |= m_busy[i];
            if (!any) m_phase = 3;
         end else if (m_phase == 3) begin
            m_phase = 0;
         end
      end
      exp_busy   = (m_phase != 0);
      exp_done   = (m_phase == 3);
      exp_issued = RW'(m_next);
   endtask

   task automatic compare();
      logic [RW-1:0] r;
      check_eq("core_start",  core_start,  exp_start);
      check_eq("core_row",    core_row,    exp_row);
      check_eq("busy",        busy,        exp_busy);
      check_eq("all_done",    all_done,    exp_done);
      check_eq("rows_issued", rows_issued, exp_issued);
      for (int i = 0; i < NC; i++) begin
         if (core_start[i]) begin
            obs_starts++;
            r = core_row[i*RW +: RW];
            if (row_seen[r]) obs_dups++;
            row_seen[r] = 1;
         end
      end
      if (all_done) obs_dones++;
   endtask

   // Apply inputs, let one edge pass, then compare away from the edge.
   task automatic step(input logic s, input logic [RW-1:0] n, input logic [NC-1:0] d);
      start = s; num_rows = n; core_done = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   function automatic logic [NC-1:0] model_busy_mask();
      logic [NC-1:0] m;
      for (int i = 0; i < NC; i++) m[i] = m_busy[i];
      return m;
   endfunction

   // mode 0: random completion plus spurious dones; mode 1: fixed latency.
   function automatic logic [NC-1:0] pick_done(input int mode);
      logic [NC-1:0] d;
      d = '0;
      for (int i = 0; i < NC; i++) begin
         if (mode == 1) d[i] = m_busy[i] && (m_age[i] >= 2);
         else if (m_busy[i]) d[i] = ($urandom_range(0, 2) == 0);
         else d[i] = ($urandom_range(0, 15) == 0);
      end
      return d;
   endfunction

   task automatic clear_obs();
      obs_starts = 0; obs_dones = 0; obs_dups = 0;
      for (int i = 0; i < 2**RW; i++) row_seen[i] = 0;
   endtask

   task automatic run_job(input logic [RW-1:0] n, input int mode, input int budget);
      int c;
      step(1'b1, n, pick_done(mode));
      c = 0;
      while (m_phase != 0 && c < budget) begin
         step(($urandom_range(0, 9) == 0), RW'($urandom), pick_done(mode));
         c++;
      end
      check_eq("job_timeout_busy", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_rows = '0; core_done = '0;
      model_reset();
      clear_obs();
      @(negedge clk);
      compare();
      step(1'b1, 8'd5, '0);
      step(1'b0, 8'd0, '0);
      @(negedge clk);
      rst = 1'b0;

      // Basic fill: three rows on cores 0,1,2, then done on 2,0,1.
      step(1'b1, 8'd3, '0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'd0, '0);
      step(1'b0, 8'd0, 4'b0100);
      step(1'b0, 8'd0, 4'b0001);
      step(1'b0, 8'd0, 4'b0010);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, '0);

      // Refill: row 4 goes to core 1, row 5 to core 3 rather than core 1.
      step(1'b1, 8'd6, '0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'd0, '0);
      step(1'b0, 8'd0, 4'b0010);
      step(1'b0, 8'd0, '0);
      step(1'b0, 8'd0, 4'b1010);
      step(1'b0, 8'd0, '0);
      step(1'b0, 8'd0, model_busy_mask());
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, '0);

      // Zero rows completes with no issue.
      step(1'b1, 8'd0, '0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, '0);

      // Asynchronous reset with two cores busy, then no all_done afterwards.
      step(1'b1, 8'd6, '0);
      step(1'b0, 8'd0, '0);
      step(1'b0, 8'd0, '0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare();
      @(negedge clk);
      rst = 1'b0;
      clear_obs();
      for (int i = 0; i < 6; i++) step(1'b0, 8'd0, '0);
      check_eq("no_done_after_rst", obs_dones, 0);

      // Randomized jobs with spurious dones and ignored mid-job starts.
      for (int j = 0; j < 40; j++) begin
         run_job(($urandom_range(0, 7) == 0) ? 8'd0 : RW'($urandom_range(1, 20)), 0, 600);
         if ($urandom_range(0, 1) == 0) step(1'b0, RW'($urandom), pick_done(0));
      end

      // Maximum job: 255 rows, fixed completion latency.
      clear_obs();
      run_job(8'd255, 1, 3000);
      step(1'b0, 8'd0, '0);
      step(1'b0, 8'd0, '0);
      n_seen = 0;
      for (int i = 0; i < 2**RW; i++) n_seen += row_seen[i];
      check_eq("max_starts", obs_starts, 255);
      check_eq("max_rows_unique", n_seen, 255);
      check_eq("max_dups", obs_dups, 0);
      check_eq("max_all_done", obs_dones, 1);
      check_eq("max_rows_issued", rows_issued, 8'd255);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
